// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundle of every non-clock/reset signal of trap_ctrl.
//   master : commit stage / CSR file side (drives the events and CSR values,
//            receives the write strobes, flush and redirect).
//   slave  : trap_ctrl itself.
// Event inputs: inst_valid_i, pc_i, inst_i, fault_addr_i, e_*_i, is_mret_i,
//   meip_i/mtip_i/msip_i.  CSR inputs: mstatus_i, mie_i, exc_ret_addr_i.
// Outputs: we_exc_o, is_int_o, m*_d_o write data, sel_exc_nret_o, flush_o,
//   busy_o, redirect_valid_o, redirect_pc_o.
interface trap_ctrl_if;
    logic        inst_valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [31:0] fault_addr_i;
    logic        e_inst_misaligned_i;
    logic        e_illegal_inst_i;
    logic        e_ebreak_i;
    logic        e_ecall_i;
    logic        e_load_misaligned_i;
    logic        e_store_misaligned_i;
    logic        is_mret_i;
    logic        meip_i;
    logic        mtip_i;
    logic        msip_i;
    logic [31:0] mstatus_i;
    logic [31:0] mie_i;
    logic [31:0] exc_ret_addr_i;
    logic        we_exc_o;
    logic [31:0] mcause_d_o;
    logic [31:0] mepc_d_o;
    logic [31:0] mtval_d_o;
    logic [31:0] mstatus_d_o;
    logic [31:0] mip_d_o;
    logic        is_int_o;
    logic        sel_exc_nret_o;
    logic        flush_o;
    logic        busy_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    modport master (
        output inst_valid_i, pc_i, inst_i, fault_addr_i,
               e_inst_misaligned_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i,
               e_load_misaligned_i, e_store_misaligned_i, is_mret_i,
               meip_i, mtip_i, msip_i, mstatus_i, mie_i, exc_ret_addr_i,
        input  we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o,
               is_int_o, sel_exc_nret_o, flush_o, busy_o,
               redirect_valid_o, redirect_pc_o
    );

    modport slave (
        input  inst_valid_i, pc_i, inst_i, fault_addr_i,
               e_inst_misaligned_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i,
               e_load_misaligned_i, e_store_misaligned_i, is_mret_i,
               meip_i, mtip_i, msip_i, mstatus_i, mie_i, exc_ret_addr_i,
        output we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o,
               is_int_o, sel_exc_nret_o, flush_o, busy_o,
               redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Collects synchronous exceptions and synchronised interrupt lines, picks the
// highest-priority event, drives the CSR write handshake (TRAP_WR / MRET_WR)
// with a one-cycle flush, then issues a one-cycle fetch redirect.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : trap_ctrl_if.slave, all event/CSR/strobe signals
// Parameters:
//   SYNC_STAGES : interrupt synchroniser depth (values below 2 are raised to 2)
//   VECTORED    : 1 = interrupt redirect adds 4*cause to the mtvec base
module trap_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter bit VECTORED    = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    trap_ctrl_if.slave bus
);
    localparam int SYNC_D = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_TRAP_WR  = 2'd1;
    localparam logic [1:0] ST_MRET_WR  = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    // Synchroniser lanes: [2]=meip, [1]=mtip, [0]=msip
    logic [SYNC_D-1:0][2:0] sync_q, sync_d;
    logic [1:0]  state_q, state_d;
    logic        is_int_q, is_int_d;
    logic        ret_q, ret_d;
    logic [31:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d;
    logic [31:0] sh_cause_q, sh_cause_d, sh_epc_q, sh_epc_d, sh_tval_q, sh_tval_d;

    logic [31:0] mip, int_en, int_cause, exc_cause, exc_tval;
    logic        int_pend, exc_any;

    always_comb begin
        sync_d[0] = {bus.meip_i, bus.mtip_i, bus.msip_i};
        for (int i = 1; i < SYNC_D; i++) sync_d[i] = sync_q[i-1];
    end

    assign mip = {20'b0, sync_q[SYNC_D-1][2], 3'b0, sync_q[SYNC_D-1][1], 3'b0,
                  sync_q[SYNC_D-1][0], 3'b0};
    assign int_en   = bus.mie_i & mip;
    assign int_pend = bus.mstatus_i[3] & (|int_en) & bus.inst_valid_i;

    // MEI > MSI > MTI
    always_comb begin
        if (int_en[11])     int_cause = 32'h8000_000B;
        else if (int_en[3]) int_cause = 32'h8000_0003;
        else                int_cause = 32'h8000_0007;
    end

    always_comb begin
        exc_any   = bus.inst_valid_i & (bus.e_inst_misaligned_i | bus.e_illegal_inst_i |
                    bus.e_ebreak_i | bus.e_ecall_i | bus.e_load_misaligned_i |
                    bus.e_store_misaligned_i);
        exc_cause = 32'd0;
        exc_tval  = 32'd0;
        if (bus.e_inst_misaligned_i) begin
            exc_cause = 32'd0;
            exc_tval  = bus.fault_addr_i;
        end else if (bus.e_illegal_inst_i) begin
            exc_cause = 32'd2;
            exc_tval  = bus.inst_i;
        end else if (bus.e_ebreak_i) begin
            exc_cause = 32'd3;
        end else if (bus.e_ecall_i) begin
            exc_cause = 32'd11;
        end else if (bus.e_load_misaligned_i) begin
            exc_cause = 32'd4;
            exc_tval  = bus.fault_addr_i;
        end else if (bus.e_store_misaligned_i) begin
            exc_cause = 32'd6;
            exc_tval  = bus.fault_addr_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_int_d   = is_int_q;
        ret_d      = ret_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        tval_d     = tval_q;
        sh_cause_d = sh_cause_q;
        sh_epc_d   = sh_epc_q;
        sh_tval_d  = sh_tval_q;
        case (state_q)
            ST_IDLE: begin
                if (int_pend) begin
                    state_d  = ST_TRAP_WR;
                    is_int_d = 1'b1;
                    ret_d    = 1'b0;
                    cause_d  = int_cause;
                    epc_d    = bus.pc_i;
                    tval_d   = 32'd0;
                end else if (exc_any) begin
                    // An exception beats a simultaneous MRET; mepc is the MRET's PC.
                    state_d  = ST_TRAP_WR;
                    is_int_d = 1'b0;
                    ret_d    = 1'b0;
                    cause_d  = exc_cause;
                    epc_d    = bus.pc_i;
                    tval_d   = exc_tval;
                end else if (bus.inst_valid_i && bus.is_mret_i) begin
                    state_d  = ST_MRET_WR;
                    is_int_d = 1'b0;
                    ret_d    = 1'b1;
                end
            end
            ST_TRAP_WR: begin
                state_d    = ST_REDIRECT;
                // Shadow tracks what the CSR file now holds, replayed on MRET.
                sh_cause_d = cause_q;
                sh_epc_d   = epc_q;
                sh_tval_d  = tval_q;
            end
            ST_MRET_WR:  state_d = ST_REDIRECT;
            default:     state_d = ST_IDLE;
        endcase
    end

    logic        we_exc, is_int, flush, sel, redir;
    logic [31:0] mcause_o, mepc_o, mtval_o, mstatus_o, rpc;

    always_comb begin
        we_exc    = 1'b0;
        is_int    = 1'b0;
        flush     = 1'b0;
        redir     = 1'b0;
        mcause_o  = 32'd0;
        mepc_o    = 32'd0;
        mtval_o   = 32'd0;
        mstatus_o = 32'd0;
        rpc       = 32'd0;
        // sel stays at its write-phase value through REDIRECT
        sel       = (state_q != ST_IDLE) & ret_q;
        case (state_q)
            ST_TRAP_WR: begin
                we_exc         = 1'b1;
                is_int         = is_int_q;
                flush          = 1'b1;
                mcause_o       = cause_q;
                mepc_o         = epc_q;
                mtval_o        = tval_q;
                mstatus_o      = bus.mstatus_i;
                mstatus_o[7]   = bus.mstatus_i[3];
                mstatus_o[3]   = 1'b0;
                mstatus_o[12:11] = 2'b11;
            end
            ST_MRET_WR: begin
                we_exc         = 1'b1;
                flush          = 1'b1;
                mcause_o       = sh_cause_q;
                mepc_o         = sh_epc_q;
                mtval_o        = sh_tval_q;
                mstatus_o      = bus.mstatus_i;
                mstatus_o[3]   = bus.mstatus_i[7];
                mstatus_o[7]   = 1'b1;
                mstatus_o[12:11] = 2'b11;
            end
            ST_REDIRECT: begin
                redir = 1'b1;
                rpc   = {bus.exc_ret_addr_i[31:2], 2'b00};
                if (VECTORED && is_int_q) rpc = rpc + {25'd0, cause_q[4:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            is_int_q   <= 1'b0;
            ret_q      <= 1'b0;
            sh_cause_q <= 32'd0;
            sh_epc_q   <= 32'd0;
            sh_tval_q  <= 32'd0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            is_int_q   <= is_int_d;
            ret_q      <= ret_d;
            sh_cause_q <= sh_cause_d;
            sh_epc_q   <= sh_epc_d;
            sh_tval_q  <= sh_tval_d;
        end
    end

    // Event data is only visible through state-gated outputs, so no reset needed.
    always_ff @(posedge clk_i) begin
        cause_q <= cause_d;
        epc_q   <= epc_d;
        tval_q  <= tval_d;
    end

    assign bus.we_exc_o         = we_exc;
    assign bus.is_int_o         = is_int;
    assign bus.flush_o          = flush;
    assign bus.sel_exc_nret_o   = sel;
    assign bus.busy_o           = (state_q != ST_IDLE);
    assign bus.redirect_valid_o = redir;
    assign bus.redirect_pc_o    = rpc;
    assign bus.mcause_d_o       = mcause_o;
    assign bus.mepc_d_o         = mepc_o;
    assign bus.mtval_d_o        = mtval_o;
    assign bus.mstatus_d_o      = mstatus_o;
    assign bus.mip_d_o          = mip;
endmodule
